mod_cnt3: RTL and testbench

Ternary (modulo-3) digit counter used as one digit stage of the base-3 Halton sequence generator. Each enabled clock advances the digit 0 → 1 → 2 → 0. The block emits a carry on wrap so identical stages can be chained to form a multi-digit base-3 counter, from which the Halton generator builds its digit-reversed output.

---
 rtl/mod_cnt3.sv | 37 +++
 tb/tb_mod_cnt3.sv | 113 +++++++++++
 2 files changed

// File: rtl/mod_cnt3.sv
// Modulo-3 digit counter: one base-3 digit stage, chainable through cin/cout.
// Latency: out updates 1 clock after cin=1 is sampled; cout is combinational (0 cycles).
// Backpressure: none; cin is a plain enable and is never stalled.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-low reset, has priority over counting
//   cin  - count enable / carry-in from the less significant stage
//   cout - carry-out to the more significant stage, high when this stage wraps next edge
//   out  - current digit value, 0..2
module mod_cnt3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       cin,
  output logic       cout,
  output logic [1:0] out
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= 2'd0;
    end else if (cin) begin
      // Digit 2 wraps to 0. The unreachable code 3 also loads 0 here,
      // so an upset register recovers on the next enabled edge.
      if (out < 2'd2) begin
        out <= out + 2'd1;
      end else begin
        out <= 2'd0;
      end
    end
  end

  // Combinational carry, so a chained stage increments on the same edge this one wraps.
  // Decoding out == 2 exactly keeps cout low while out holds the illegal code 3.
  assign cout = cin & (out == 2'd2);

endmodule

// File: tb/tb_mod_cnt3.sv
// Self-checking bench for mod_cnt3 against an integer modulo-3 reference model.
// Inputs are driven on the falling edge; cout is sampled mid-cycle, out #1 after the rising edge.
// No handshake on the DUT, so no waits are open-ended.
module tb_mod_cnt3;

  logic       clk;
  logic       rst;
  logic       cin;
  logic       cout;
  logic [1:0] out;

  int n_checks;
  int n_pass;

  // Reference digit and whether it is defined yet (undefined before the first reset edge).
  int model;
  bit model_known;

  mod_cnt3 dut (
    .clk  (clk),
    .rst  (rst),
    .cin  (cin),
    .cout (cout),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One clock: drive rst/cin, check the combinational carry, clock, then check the digit.
  task automatic step(input logic r, input logic c, input string tag);
    @(negedge clk);
    rst = r;
    cin = c;
    #1;
    if (model_known) begin
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, (c && model == 2)});
    end
    @(posedge clk);
    if (!r) begin
      model = 0;
      model_known = 1'b1;
    end else if (c && model_known) begin
      model = (model + 1) % 3;
    end
    #1;
    if (model_known) begin
      check({tag, "_out"}, {30'd0, out}, model);
      check({tag, "_legal"}, {31'd0, (out != 2'd3)}, 32'd1);
    end
  endtask

  initial begin
    int exp_seq[7];
    n_checks    = 0;
    n_pass      = 0;
    model       = 0;
    model_known = 1'b0;
    rst = 1'b0;
    cin = 1'b0;

    // Reset held for two edges with random enable.
    step(1'b0, 1'($urandom_range(0, 1)), "reset0");
    step(1'b0, 1'($urandom_range(0, 1)), "reset1");
    check("reset_out_const", {30'd0, out}, 32'd0);
    check("reset_cout_const", {31'd0, cout}, 32'd0);

    // Continuous count, also compared against the literal expected sequence.
    exp_seq = '{1, 2, 0, 1, 2, 0, 1};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, "count");
      check("count_seq", {30'd0, out}, exp_seq[i]);
    end

    // Hold at 1 with cin low.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, "hold");
      check("hold_val", {30'd0, out}, 32'd1);
    end

    // Carry gating: reach 2, hold with cin=0, then enable and wrap.
    step(1'b1, 1'b1, "to2");
    step(1'b1, 1'b0, "gate_hold");
    check("gate_hold_val", {30'd0, out}, 32'd2);
    step(1'b1, 1'b1, "gate_wrap");
    check("gate_wrap_val", {30'd0, out}, 32'd0);

    // Reset while a wrap is pending: no increment, digit cleared.
    step(1'b1, 1'b1, "mid_a");
    step(1'b1, 1'b1, "mid_b");
    check("mid_at2", {30'd0, out}, 32'd2);
    step(1'b0, 1'b1, "mid_rst");
    check("mid_rst_val", {30'd0, out}, 32'd0);

    // Random enable traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
